// File: rtl/nibble_cpu_pkg.sv
// Shared constants for the nibble accumulator core: opcodes, FSM states,
// the RET sentinel address and the operand beat-count helper.
package nibble_cpu_pkg;

  localparam logic [3:0] OP_NGA  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BLE  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_LDA  = 4'hC;
  localparam logic [3:0] OP_LDB  = 4'hD;
  localparam logic [3:0] OP_STA  = 4'hE;
  localparam logic [3:0] OP_STB  = 4'hF;

  typedef enum logic [1:0] {ST_FETCH, ST_OPND, ST_MEMRD, ST_MEMWR} state_e;

  // Opcode 8 with an all-ones operand is RET; slice to the address width.
  localparam logic [31:0] RET_ADDR = '1;

  function automatic int ab(input int dw, input int aw);
    return (aw + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/nibble_cpu_stack.sv
// Return-address LIFO for CALL/RET; overflow/underflow are refused here and
// reported by the core.
module nibble_cpu_stack #(
  parameter int AW = 7,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(SD + 1);
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;

  logic [SD-1:0][AW-1:0] mem_q, mem_d;
  logic [PW-1:0]         sp_q, sp_d;
  logic [IW-1:0]         wr_idx, rd_idx;

  assign full   = (sp_q == PW'(SD));
  assign empty  = (sp_q == '0);
  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - 1'b1);
  assign dout   = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      sp_d          = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      mem_q <= '0;
      sp_q  <= '0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
    end
  end

endmodule

// File: rtl/nibble_cpu_core.sv
// Accumulator CPU core: one bus beat per FSM state, every beat stretched by
// bus_rdy; outputs decode from registered state only.
module nibble_cpu_core
  import nibble_cpu_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 7,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic [DW-1:0] bus_in,
  input  logic          bus_rdy,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic          rd_en,
  output logic          wr_en,
  output logic          flag_c,
  output logic          stk_err
);
  localparam int AB = ab(DW, AW);
  localparam int CW = (AB > 1) ? $clog2(AB) : 1;
  localparam int SW = $clog2(DW);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, tmp_q, tmp_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          c_q, c_d, err_q, err_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW+DW-1:0] shift_in;
  logic [AW-1:0]    opnd, pc_inc, stk_dout;
  logic [DW:0]      sum;
  logic [SW-1:0]    shamt;
  logic             push, pop, stk_full, stk_empty, last_beat;

  // Operand beats arrive MS first; shifting left drops surplus MSBs.
  assign shift_in  = {tmp_q, bus_in};
  assign opnd      = shift_in[AW-1:0];
  assign pc_inc    = pc_q + 1'b1;
  assign last_beat = (cnt_q == CW'(AB - 1));
  assign shamt     = b_q[SW-1:0];
  assign sum       = {1'b0, a_q} + {1'b0, b_q};

  nibble_cpu_stack #(.AW(AW), .SD(SD)) u_stack (
    .clk   (clk),
    .rst_p (rst_p),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tmp_d   = tmp_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus_rdy) begin
      case (state_q)
        ST_FETCH: begin
          pc_d = pc_inc;
          if (bus_in[3]) begin
            op_d    = bus_in[3:0];
            cnt_d   = '0;
            state_d = ST_OPND;
          end else begin
            case (bus_in[3:0])
              OP_NGA: begin a_d = -a_q; c_d = (a_q == '0); end
              OP_AND: a_d = a_q & b_q;
              OP_OR:  a_d = a_q | b_q;
              OP_XOR: a_d = a_q ^ b_q;
              OP_SLL: a_d = a_q << shamt;
              OP_SRL: a_d = a_q >> shamt;
              OP_SRA: a_d = $unsigned($signed(a_q) >>> shamt);
              default: {c_d, a_d} = sum;
            endcase
          end
        end
        ST_OPND: begin
          pc_d  = pc_inc;
          tmp_d = opnd;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = ST_FETCH;
            case (op_q)
              OP_CALL: begin
                if (opnd == RET_ADDR[AW-1:0]) begin
                  if (stk_empty) err_d = 1'b1;
                  else begin pop = 1'b1; pc_d = stk_dout; end
                end else begin
                  // A full stack drops the return address but still jumps.
                  if (stk_full) err_d = 1'b1;
                  else push = 1'b1;
                  pc_d = opnd;
                end
              end
              OP_BEQ: if (a_q == b_q) pc_d = pc_inc + opnd;
              OP_BLE: if (a_q <= b_q) pc_d = pc_inc + opnd;
              OP_JMP: pc_d = opnd;
              OP_LDA, OP_LDB: state_d = ST_MEMRD;
              OP_STA, OP_STB: state_d = ST_MEMWR;
              default: ;
            endcase
          end
        end
        ST_MEMRD: begin
          if (op_q == OP_LDA) a_d = bus_in;
          else b_d = bus_in;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      tmp_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tmp_q   <= tmp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_out = (state_q == ST_MEMRD || state_q == ST_MEMWR) ? tmp_q : pc_q;
  assign rd_en    = (state_q != ST_MEMWR);
  assign wr_en    = (state_q == ST_MEMWR);
  assign data_out = wr_en ? ((op_q == OP_STB) ? b_q : a_q) : '0;
  assign flag_c   = c_q;
  assign stk_err  = err_q;

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Bench: ISA-level interpreter predicts the bus beat sequence; a negedge
// process compares every beat, plus directed literal checks.
module tb_nibble_cpu_core;

  logic clk, rst0, rst1, bus_rdy;
  logic [3:0]  bus_in0, data0;
  logic [6:0]  addr0;
  logic        rd0, wr0, c0, e0;
  logic [7:0]  bus_in1, data1;
  logic [11:0] addr1;
  logic        rd1, wr1, c1, e1;

  logic [7:0] mem [4096];
  int         mmem [4096];

  bit sel, chk_en, rand_stall;
  int cyc, stall_lo, stall_hi, wr_cnt;
  int n_cmp, n_fail;

  nibble_cpu_core u_dut4 (
    .clk(clk), .rst_p(rst0), .bus_in(bus_in0), .bus_rdy(bus_rdy),
    .addr_out(addr0), .data_out(data0), .rd_en(rd0), .wr_en(wr0),
    .flag_c(c0), .stk_err(e0));

  nibble_cpu_core #(.DW(8), .AW(12)) u_dut8 (
    .clk(clk), .rst_p(rst1), .bus_in(bus_in1), .bus_rdy(bus_rdy),
    .addr_out(addr1), .data_out(data1), .rd_en(rd1), .wr_en(wr1),
    .flag_c(c1), .stk_err(e1));

  assign bus_in0 = mem[addr0][3:0];
  assign bus_in1 = mem[addr1];

  int o_addr, o_data;
  logic o_rd, o_wr, o_c, o_e;
  assign o_addr = sel ? int'(addr1) : int'(addr0);
  assign o_data = sel ? int'(data1) : int'(data0);
  assign o_rd   = sel ? rd1 : rd0;
  assign o_wr   = sel ? wr1 : wr0;
  assign o_c    = sel ? c1 : c0;
  assign o_e    = sel ? e1 : e0;

  always #5 clk = ~clk;

  // ---------------- behavioural ISA model ----------------
  typedef struct { int addr; bit rd; bit wr; int data; bit c; bit e; } beat_t;
  beat_t q[$];
  int m_dw, m_aw, m_ab, m_pc, m_a, m_b, m_c, m_err;
  int m_stk[$];

  function automatic void add_beat(input int addr, input bit wr, input int data);
    beat_t t;
    t.addr = addr; t.rd = !wr; t.wr = wr; t.data = data; t.c = m_c[0]; t.e = m_err[0];
    q.push_back(t);
  endfunction

  function automatic void gen_instr();
    int dm, am, op, tmp, s, sa;
    dm = (1 << m_dw) - 1;
    am = (1 << m_aw) - 1;
    op = mmem[m_pc] & 15;
    add_beat(m_pc, 0, 0);
    m_pc = (m_pc + 1) & am;
    s = m_b % m_dw;
    if (op < 8) begin
      case (op)
        0: begin m_c = (m_a == 0); m_a = (-m_a) & dm; end
        1: m_a = m_a & m_b;
        2: m_a = m_a | m_b;
        3: m_a = m_a ^ m_b;
        4: m_a = (m_a << s) & dm;
        5: m_a = m_a >> s;
        6: begin
          sa = (m_a >= (1 << (m_dw - 1))) ? m_a - (1 << m_dw) : m_a;
          m_a = (sa >>> s) & dm;
        end
        default: begin m_a = m_a + m_b; m_c = m_a >> m_dw; m_a = m_a & dm; end
      endcase
    end else begin
      tmp = 0;
      for (int i = 0; i < m_ab; i++) begin
        add_beat(m_pc, 0, 0);
        tmp = ((tmp << m_dw) | mmem[m_pc]) & am;
        m_pc = (m_pc + 1) & am;
      end
      case (op)
        8: begin
          if (tmp == am) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = 1;
          end else begin
            if (m_stk.size() < 4) m_stk.push_back(m_pc);
            else m_err = 1;
            m_pc = tmp;
          end
        end
        9:  if (m_a == m_b) m_pc = (m_pc + tmp) & am;
        10: if (m_a <= m_b) m_pc = (m_pc + tmp) & am;
        11: m_pc = tmp;
        12: begin add_beat(tmp, 0, 0); m_a = mmem[tmp]; end
        13: begin add_beat(tmp, 0, 0); m_b = mmem[tmp]; end
        14: begin add_beat(tmp, 1, m_a); mmem[tmp] = m_a; end
        default: begin add_beat(tmp, 1, m_b); mmem[tmp] = m_b; end
      endcase
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      beat_t e;
      if (q.size() == 0) gen_instr();
      e = q[0];
      n_cmp++;
      if (o_addr != e.addr || o_rd != e.rd || o_wr != e.wr || o_data != e.data ||
          o_c != e.c || o_e != e.e) begin
        n_fail++;
        $display("FAIL beat t=%0t got addr=%0h rd=%0b wr=%0b data=%0h c=%0b err=%0b want addr=%0h rd=%0b wr=%0b data=%0h c=%0b err=%0b",
                 $time, o_addr, o_rd, o_wr, o_data, o_c, o_e, e.addr, e.rd, e.wr, e.data, e.c, e.e);
      end
      if (bus_rdy) void'(q.pop_front());
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_addr"}, o_addr, 0);
    check({p, "_rd"}, int'(o_rd), 1);
    check({p, "_wr"}, int'(o_wr), 0);
    check({p, "_data"}, o_data, 0);
    check({p, "_c"}, int'(o_c), 0);
    check({p, "_err"}, int'(o_e), 0);
  endtask

  function automatic logic pick_rdy();
    if (rand_stall) return ($urandom_range(0, 3) != 0);
    return !(cyc >= stall_lo && cyc < stall_hi);
  endfunction

  task automatic step(input int n);
    logic w;
    int wa;
    logic [7:0] wd;
    for (int i = 0; i < n; i++) begin
      w  = sel ? (wr1 && bus_rdy && !rst1) : (wr0 && bus_rdy && !rst0);
      wa = o_addr;
      wd = 8'(o_data);
      @(posedge clk); #1;
      if (w) begin mem[wa] = wd; wr_cnt++; end
      cyc++;
      bus_rdy = pick_rdy();
    end
  endtask

  task automatic wait_addr(input int a, input int budget, input string nm);
    int k;
    k = 0;
    while (o_addr != a && k < budget) begin step(1); k++; end
    check(nm, o_addr, a);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic start(input bit s);
    chk_en = 0; rst0 = 1; rst1 = 1; sel = s;
    m_dw = s ? 8 : 4; m_aw = s ? 12 : 7; m_ab = (m_aw + m_dw - 1) / m_dw;
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_err = 0;
    m_stk.delete(); q.delete();
    for (int i = 0; i < 4096; i++) mmem[i] = int'(mem[i]) & ((1 << m_dw) - 1);
    wr_cnt = 0;
    @(posedge clk); #1;
    check_reset("reset");
    cyc = 0;
    bus_rdy = pick_rdy();
    if (s) rst1 = 0; else rst0 = 0;
    chk_en = 1;
  endtask

  task automatic put(input int base, input int v0, input int v1, input int v2);
    mem[base] = 8'(v0); mem[base+1] = 8'(v1); mem[base+2] = 8'(v2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clk = 0; rst0 = 1; rst1 = 1; bus_rdy = 1; sel = 0; chk_en = 0;
    rand_stall = 0; stall_lo = 0; stall_hi = 0; cyc = 0;
    n_cmp = 0; n_fail = 0;

    // LDB 8, LDA 9, ADD, then STA lands at 0x35
    clear_mem();
    put(0, 'hD, 0, 8); put(3, 'hC, 0, 9); mem[6] = 8'h7; mem[7] = 8'hE;
    mem[8] = 8'h3; mem[9] = 8'h5;
    start(0);
    step(9);
    check("prog_pc", o_addr, 7);
    check("model_a", m_a, 8);
    check("model_c", m_c, 0);
    step(4);
    check("prog_store", int'(mem['h35]), 8);
    check("prog_c", int'(o_c), 0);

    // STA to 0x2A with A=0xB
    clear_mem();
    put(0, 'hC, 2, 0); put(3, 'hE, 2, 'hA); mem['h20] = 8'hB;
    start(0);
    step(7);
    check("sta_addr", o_addr, 'h2A);
    check("sta_wr", int'(o_wr), 1);
    check("sta_data", o_data, 'hB);
    step(1);
    check("sta_mem", int'(mem['h2A]), 'hB);
    check("sta_beats", wr_cnt, 1);

    // JMP with 3 stall cycles during first operand beat
    clear_mem();
    put(0, 'hB, 4, 5);
    stall_lo = 1; stall_hi = 4;
    start(0);
    step(4);
    check("stall_hold", o_addr, 1);
    step(1);
    check("stall_opnd2", o_addr, 2);
    step(1);
    check("stall_retire", o_addr, 'h45);
    stall_lo = 0; stall_hi = 0;

    // five nested CALLs then five RETs
    clear_mem();
    put(0, 8, 1, 0); put('h10, 8, 2, 0); put('h20, 8, 3, 0);
    put('h30, 8, 4, 0); put('h40, 8, 5, 0);
    put('h50, 8, 7, 'hF); put('h33, 8, 7, 'hF); put('h23, 8, 7, 'hF);
    put('h13, 8, 7, 'hF); put(3, 8, 7, 'hF);
    start(0);
    wait_addr('h40, 40, "call4");
    check("call4_err", int'(o_e), 0);
    wait_addr('h50, 10, "call5");
    check("call5_err", int'(o_e), 1);
    wait_addr('h33, 10, "ret1");
    wait_addr('h23, 10, "ret2");
    wait_addr('h13, 10, "ret3");
    wait_addr('h03, 10, "ret4");
    wait_addr('h06, 10, "ret5_fall");
    check("ret_err", int'(o_e), 1);

    // BLE at 0 after wrap-around setup code; taken then not taken
    for (int v = 0; v < 2; v++) begin
      clear_mem();
      put(0, 'hB, 6, 'hB);
      put('h6B, 'hD, 5, 3); put('h6E, 'hC, 5, 1); put('h71, 'hE, 0, 0);
      put('h74, 'hC, 5, 2); put('h77, 'hE, 0, 2); put('h7A, 'hC, 5, 0);
      put('h7D, 'hF, 0, 1);
      mem['h50] = (v == 0) ? 8'h7 : 8'h8; mem['h51] = 8'hA; mem['h52] = 8'hE; mem['h53] = 8'h7;
      start(0);
      step(31);
      check("ble_wrap_pc", o_addr, 0);
      step(3);
      check(v == 0 ? "ble_taken" : "ble_not_taken", o_addr, v == 0 ? 1 : 3);
      step(20);
    end

    // random programs, random wait states
    clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 15));
    rand_stall = 1;
    start(0);
    step(3000);
    rand_stall = 0;

    // wide core: ADD carry, stores, reset during MEMWR
    clear_mem();
    put(0, 'h0C, 0, 'h40); put(3, 'h0D, 0, 'h41); mem[6] = 8'h07;
    put(7, 'h0E, 0, 'h50); put('hA, 'h0F, 0, 'h60);
    mem['h40] = 8'hFF; mem['h41] = 8'h01; mem['h50] = 8'hAA; mem['h60] = 8'hAA;
    start(1);
    step(9);
    check("w_add_c", int'(o_c), 1);
    check("w_model_a", m_a, 0);
    check("w_model_c", m_c, 1);
    step(4);
    check("w_sta_mem", int'(mem['h50]), 0);
    step(3);
    check("w_memwr_addr", o_addr, 'h060);
    check("w_memwr_wr", int'(o_wr), 1);
    check("w_memwr_data", o_data, 1);
    @(negedge clk); #2;
    chk_en = 0;
    rst1 = 1;
    #1;
    check_reset("abort");
    @(posedge clk); #1;
    check("abort_mem", int'(mem['h60]), 'hAA);
    check("abort_wr", int'(o_wr), 0);

    // random programs on the wide core
    clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));
    rand_stall = 1;
    start(1);
    step(2000);
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
